// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the word-serial multi-word adder.
package multiword_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    // Word index width; a single-word operand still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
module rca_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial adder: one shared WIDTH-bit slice processes WORDS words LSW first,
// carrying between words in a register, behind valid/ready handshakes.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int IW = idx_width(WORDS);

    seq_state_t                  state, state_nxt;
    logic [WORDS-1:0][WIDTH-1:0] a_q, b_q, sum_q;
    logic [IW-1:0]               idx;
    logic                        carry_q, cout_q;
    logic [WIDTH-1:0]            s_sum;
    logic                        s_cout;
    logic                        last;

    assign last = (idx == IW'(WORDS - 1));

    rca_slice #(.WIDTH(WIDTH)) u_slice (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .cin (carry_q),
        .sum (s_sum),
        .cout(s_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    idx     <= '0;
                    carry_q <= 1'b0;
                end
                RUN: begin
                    sum_q[idx] <= s_sum;
                    carry_q    <= s_cout;
                    if (last) cout_q <= s_cout;
                    else      idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: a WORDS=4 instance and a WORDS=1 instance.
module tb_multiword_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b1;
    logic [15:0] a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [15:0] sum4;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, busy1;
    logic [3:0]  sum1;

    int n_cmp = 0;
    int n_err = 0;

    multiword_add_seq #(.WIDTH(4), .WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    multiword_add_seq #(.WIDTH(4), .WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair to the WORDS=4 instance and wait for out_valid.
    task automatic start4(input logic [15:0] x, input logic [15:0] y, output int lat);
        in_valid4 = 1'b1;
        a4 = x;
        b4 = y;
        step();
        in_valid4 = 1'b0;
        a4 = ~x;
        b4 = ~y;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    int lat, c, nres;
    logic [16:0] ref1;
    logic [3:0]  ra, rb;
    logic [4:0]  rsum;

    initial begin
        // reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid4), 64'd0);
        chk("rst_sum",       64'(sum4),       64'd0);
        chk("rst_cout",      64'(cout4),      64'd0);
        chk("rst_busy",      64'(busy4),      64'd0);
        chk("rst_in_ready",  64'(in_ready4),  64'd1);
        chk("rst_in_ready1", 64'(in_ready1),  64'd1);

        // 1: basic add, latency WORDS
        start4(16'h1234, 16'h4321, lat);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_sum",     64'(sum4),  64'h5555);
        chk("t1_cout",    64'(cout4), 64'd0);
        chk("t1_in_ready_done", 64'(in_ready4), 64'd0);
        step();
        chk("t1_out_valid_drop", 64'(out_valid4), 64'd0);
        chk("t1_in_ready_back",  64'(in_ready4),  64'd1);

        // 2: carry across all words
        start4(16'hFFFF, 16'h0001, lat);
        chk("t2_latency", 64'(lat), 64'd4);
        chk("t2_sum",     64'(sum4),  64'h0000);
        chk("t2_cout",    64'(cout4), 64'd1);
        step();

        // 3: back-pressure holds the result
        out_ready4 = 1'b0;
        start4(16'h8000, 16'h8000, lat);
        chk("t3_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) begin
            chk("t3_sum_hold",      64'(sum4),       64'h0000);
            chk("t3_cout_hold",     64'(cout4),      64'd1);
            chk("t3_in_ready_hold", 64'(in_ready4),  64'd0);
            step();
            chk("t3_valid_hold",    64'(out_valid4), 64'd1);
        end
        out_ready4 = 1'b1;
        step();
        chk("t3_valid_drop",  64'(out_valid4), 64'd0);
        chk("t3_in_ready",    64'(in_ready4),  64'd1);
        step();
        chk("t3_single_result", 64'(out_valid4), 64'd0);

        // 4: reset in RUN at idx=2 discards the partial result
        in_valid4 = 1'b1;
        a4 = 16'hFFFF;
        b4 = 16'h1111;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        chk("t4_busy_before_rst", 64'(busy4), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst_in_ready",  64'(in_ready4),  64'd1);
        chk("t4_rst_busy",      64'(busy4),      64'd0);
        chk("t4_rst_out_valid", 64'(out_valid4), 64'd0);
        chk("t4_rst_sum",       64'(sum4),       64'd0);
        chk("t4_rst_cout",      64'(cout4),      64'd0);
        start4(16'h00FF, 16'h0001, lat);
        chk("t4_latency", 64'(lat), 64'd4);
        chk("t4_sum",     64'(sum4),  64'h0100);
        chk("t4_cout",    64'(cout4), 64'd0);
        step();

        // 5: in_valid held high across two operand pairs
        in_valid4 = 1'b1;
        a4 = 16'hABCD;
        b4 = 16'h1111;
        step();
        a4 = 16'h7FFF;
        b4 = 16'h8001;
        c = 0;
        nres = 0;
        while (!in_ready4 && c < 20) begin
            step();
            c++;
            if (out_valid4) begin
                nres++;
                chk("t5_sum1",  64'(sum4),  64'hBCDE);
                chk("t5_cout1", 64'(cout4), 64'd0);
            end
        end
        chk("t5_nres1", 64'(nres), 64'd1);
        // in_ready seen after edge 5 means acceptance on edge 6 = WORDS+2
        chk("t5_issue_interval", 64'(c + 1), 64'd6);
        step();
        in_valid4 = 1'b0;
        chk("t5_second_accept", 64'(busy4), 64'd1);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            step();
            lat++;
        end
        chk("t5_latency2", 64'(lat), 64'd4);
        chk("t5_sum2",  64'(sum4),  64'h0000);
        chk("t5_cout2", 64'(cout4), 64'd1);
        step();

        // 6: WORDS=1 directed
        in_valid1 = 1'b1;
        a1 = 4'hF;
        b1 = 4'h1;
        step();
        in_valid1 = 1'b0;
        chk("t6_not_yet", 64'(out_valid1), 64'd0);
        step();
        chk("t6_valid", 64'(out_valid1), 64'd1);
        chk("t6_sum",   64'(sum1),  64'h0);
        chk("t6_cout",  64'(cout1), 64'd1);
        step();

        // 6: WORDS=1 random against a+b, random out_ready
        for (int k = 0; k < 1000; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rsum = {1'b0, ra} + {1'b0, rb};
            in_valid1 = 1'b1;
            a1 = ra;
            b1 = rb;
            c = 0;
            while (!in_ready1 && c < 20) begin
                step();
                c++;
            end
            step();
            in_valid1 = 1'b0;
            a1 = ~ra;
            lat = 0;
            while (!out_valid1 && lat < 20) begin
                step();
                lat++;
            end
            if (lat != 1 || sum1 !== rsum[3:0] || cout1 !== rsum[4]) begin
                chk("t6r_latency", 64'(lat),   64'd1);
                chk("t6r_sum",     64'(sum1),  64'(rsum[3:0]));
                chk("t6r_cout",    64'(cout1), 64'(rsum[4]));
            end else begin
                n_cmp++;
            end
            c = 0;
            while (out_valid1 && c < 20) begin
                out_ready1 = 1'($urandom_range(0, 1));
                step();
                c++;
                if (out_valid1) chk("t6r_hold", 64'({cout1, sum1}), 64'(rsum));
            end
            chk("t6r_drained", 64'(out_valid1), 64'd0);
        end
        out_ready1 = 1'b1;

        ref1 = 17'h0FFFF + 17'h00001;
        start4(16'hFFFF, 16'h0001, lat);
        chk("final_sum",  64'(sum4),  64'(ref1[15:0]));
        chk("final_cout", 64'(cout4), 64'(ref1[16]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
